// File: rtl/hc_pkg.sv
// Shared types, constants and the LFSR step function for the pattern sequencer.
// HC_PATTERN_PAUSE_EN adds the PAUSE state to the state enum.
package hc_pkg;

    localparam int HC_LFSR_W = 16;
    localparam logic [HC_LFSR_W-1:0] HC_LFSR_TAPS = 16'hD008;
    localparam logic [HC_LFSR_W-1:0] HC_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        HC_IDLE = 2'd0,
        HC_RUN  = 2'd1,
        HC_FIN  = 2'd2
`ifdef HC_PATTERN_PAUSE_EN
        ,
        HC_PAUSE = 2'd3
`endif
    } hc_pat_state_t;

    // Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [HC_LFSR_W-1:0] hc_lfsr_next(
        input logic [HC_LFSR_W-1:0] v,
        input logic [HC_LFSR_W-1:0] taps
    );
        return {v[HC_LFSR_W-2:0], ^(v & taps)};
    endfunction

endpackage

// File: rtl/hc_lfsr16_core.sv
// 16-bit Fibonacci LFSR register with load/step enables and zero lock-up guard.
// Priority: load, then step, then guard repair.
module hc_lfsr16_core
    import hc_pkg::*;
#(
    parameter logic [HC_LFSR_W-1:0] TAPS = HC_LFSR_TAPS,
    parameter logic [HC_LFSR_W-1:0] SEED = HC_DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [HC_LFSR_W-1:0] load_val,
    input  logic                 step,
    input  logic                 guard,
    output logic [HC_LFSR_W-1:0] data
);

    logic [HC_LFSR_W-1:0] lfsr_q;
    logic                 is_zero;

    // A zero register is presented (and stepped) as SEED so the
    // downstream never sees the lock-up word.
    assign is_zero = (lfsr_q == '0);
    assign data    = is_zero ? SEED : lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (load) begin
            lfsr_q <= load_val;
        end else if (step) begin
            lfsr_q <= hc_lfsr_next(data, TAPS);
        end else if (guard && is_zero) begin
            lfsr_q <= SEED;
        end
    end

endmodule

// File: rtl/hc_pattern_ctrl.sv
// Burst sequencer for the LFSR pattern source with valid/ready output.
// Optional feature macro: HC_PATTERN_PAUSE_EN (adds pause input and PAUSE state).
module hc_pattern_ctrl
    import hc_pkg::*;
#(
    parameter int               WIDTH        = HC_LFSR_W,
    parameter logic [WIDTH-1:0] TAPS         = HC_LFSR_TAPS,
    parameter int               LEN_W        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = HC_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_seed_vld,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
`ifdef HC_PATTERN_PAUSE_EN
    input  logic             pause,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] word_cnt
);

    hc_pat_state_t state_q, state_d;

    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] load_val;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;

    logic seed_ld;
    logic burst_ld;
    logic step;
    logic guard;

    // Zero seed would lock the LFSR, so it is replaced on entry.
    assign seed_in  = (cfg_seed == '0) ? DEFAULT_SEED : cfg_seed;
    assign load_val = cfg_seed_vld ? seed_in : seed_q;
    assign cnt_inc  = cnt_q + 1'b1;
    assign word_cnt = cnt_q;

    always_comb begin
        state_d   = state_q;
        seed_ld   = 1'b0;
        burst_ld  = 1'b0;
        step      = 1'b0;
        guard     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            HC_IDLE: begin
                busy    = 1'b0;
                seed_ld = cfg_seed_vld;
                if (start) begin
                    burst_ld = 1'b1;
                    state_d  = (burst_len == '0) ? HC_FIN : HC_RUN;
                end
            end
            HC_RUN: begin
                out_valid = 1'b1;
                guard     = 1'b1;
                if (out_ready) begin
                    step = 1'b1;
                    if (cnt_inc == len_q) begin
                        state_d = HC_FIN;
                    end
`ifdef HC_PATTERN_PAUSE_EN
                    else if (pause) begin
                        state_d = HC_PAUSE;
                    end
`endif
                end
            end
`ifdef HC_PATTERN_PAUSE_EN
            HC_PAUSE: begin
                if (!pause) begin
                    state_d = HC_RUN;
                end
            end
`endif
            HC_FIN: begin
                done    = 1'b1;
                state_d = HC_IDLE;
            end
            default: begin
                state_d = HC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q <= DEFAULT_SEED;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (seed_ld) begin
                seed_q <= seed_in;
            end
            if (burst_ld) begin
                len_q <= burst_len;
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    hc_lfsr16_core #(
        .TAPS (TAPS),
        .SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (burst_ld),
        .load_val (load_val),
        .step     (step),
        .guard    (guard),
        .data     (out_data)
    );

endmodule

// File: tb/tb_hc_pattern_ctrl.sv
// Directed bench for hc_pattern_ctrl; pause scenario built with HC_PATTERN_PAUSE_EN.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hc_pattern_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_seed_vld = 1'b0;
    logic [15:0] cfg_seed = '0;
    logic        start = 1'b0;
    logic [7:0]  burst_len = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic [7:0]  word_cnt;
`ifdef HC_PATTERN_PAUSE_EN
    logic        pause = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hc_pattern_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_seed_vld (cfg_seed_vld),
        .cfg_seed     (cfg_seed),
        .start        (start),
        .burst_len    (burst_len),
`ifdef HC_PATTERN_PAUSE_EN
        .pause        (pause),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done),
        .word_cnt     (word_cnt)
    );

    task automatic load_seed(input logic [15:0] v);
        cfg_seed_vld = 1'b1;
        cfg_seed     = v;
        @(negedge clk);
        cfg_seed_vld = 1'b0;
    endtask

    task automatic start_burst(input logic [7:0] n);
        start     = 1'b1;
        burst_len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000", {out_valid, busy, done});
        end
        total++;
        if (out_data !== 16'hACE1 || word_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_vals got=%h/%0d want=ace1/0", out_data, word_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default_burst;
        logic [15:0] exp [3];
        exp = '{16'hACE1, 16'h59C3, 16'hB386};
        out_ready = 1'b1;
        start_burst(8'd3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                bad++;
                $display("FAIL dflt_word%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp[i]);
            end
            @(negedge clk);
        end
        total++;
        if ({out_valid, busy, done} !== 3'b011 || word_cnt !== 8'd3) begin
            bad++;
            $display("FAIL dflt_fin got=%b/%0d want=011/3", {out_valid, busy, done}, word_cnt);
        end
        @(negedge clk);
        total++;
        if ({out_valid, busy, done} !== 3'b000 || word_cnt !== 8'd3) begin
            bad++;
            $display("FAIL dflt_idle got=%b/%0d want=000/3", {out_valid, busy, done}, word_cnt);
        end
    endtask

    task automatic test_seed_burst;
        logic [15:0] exp [5];
        exp = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0011};
        load_seed(16'h0001);
        start_burst(8'd5);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                bad++;
                $display("FAIL seed_word%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp[i]);
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || word_cnt !== 8'd5) begin
            bad++;
            $display("FAIL seed_done got=%b/%0d want=1/5", done, word_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_stall;
        logic [15:0] exp [5];
        logic        pat [8];
        int          k;
        int          cyc;
        exp = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0011};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        start_burst(8'd5);
        k   = 0;
        cyc = 0;
        while (k < 5 && cyc < 40) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[k] || word_cnt !== k[7:0]) begin
                bad++;
                $display("FAIL stall_c%0d got=%b/%h/%0d want=1/%h/%0d",
                         cyc, out_valid, out_data, word_cnt, exp[k], k);
            end
            out_ready = pat[cyc % 8];
            @(negedge clk);
            if (out_ready) k++;
            cyc++;
        end
        out_ready = 1'b1;
        total++;
        if (k != 5 || done !== 1'b1 || word_cnt !== 8'd5) begin
            bad++;
            $display("FAIL stall_end got=k%0d/%b/%0d want=k5/1/5", k, done, word_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_seed;
        load_seed(16'h0000);
        start_burst(8'd1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'hACE1) begin
            bad++;
            $display("FAIL zero_seed got=%b/%h want=1/ace1", out_valid, out_data);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || word_cnt !== 8'd1) begin
            bad++;
            $display("FAIL zero_done got=%b/%0d want=1/1", done, word_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_len_zero;
        start_burst(8'd0);
        total++;
        if ({out_valid, busy, done} !== 3'b011 || word_cnt !== 8'd0) begin
            bad++;
            $display("FAIL len0_fin got=%b/%0d want=011/0", {out_valid, busy, done}, word_cnt);
        end
        @(negedge clk);
        total++;
        if ({out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL len0_idle got=%b want=000", {out_valid, busy, done});
        end
    endtask

    task automatic test_ignore_busy;
        logic [15:0] exp [4];
        exp = '{16'hACE1, 16'h59C3, 16'hB386, 16'h670C};
        out_ready = 1'b0;
        start_burst(8'd4);
        cfg_seed_vld = 1'b1;
        cfg_seed     = 16'h1234;
        start_burst(8'd1);
        cfg_seed_vld = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'hACE1 || word_cnt !== 8'd0) begin
            bad++;
            $display("FAIL ign_hold got=%b/%h/%0d want=1/ace1/0", out_valid, out_data, word_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                bad++;
                $display("FAIL ign_word%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp[i]);
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || word_cnt !== 8'd4) begin
            bad++;
            $display("FAIL ign_done got=%b/%0d want=1/4", done, word_cnt);
        end
        @(negedge clk);
        start_burst(8'd1);
        total++;
        if (out_data !== 16'hACE1) begin
            bad++;
            $display("FAIL ign_seed got=%h want=ace1", out_data);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_with_cfg;
        cfg_seed_vld = 1'b1;
        cfg_seed     = 16'h0008;
        start_burst(8'd2);
        cfg_seed_vld = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0008) begin
            bad++;
            $display("FAIL same_cyc_w0 got=%b/%h want=1/0008", out_valid, out_data);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0011) begin
            bad++;
            $display("FAIL same_cyc_w1 got=%b/%h want=1/0011", out_valid, out_data);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        load_seed(16'h0001);
        start_burst(8'd4);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0002) begin
            bad++;
            $display("FAIL rstmid_w1 got=%b/%h want=1/0002", out_valid, out_data);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, busy, done} !== 3'b000 || out_data !== 16'hACE1 || word_cnt !== 8'd0) begin
            bad++;
            $display("FAIL rstmid_now got=%b/%h/%0d want=000/ace1/0",
                     {out_valid, busy, done}, out_data, word_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || out_valid) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_quiet got=%b want=0", saw_done);
        end
    endtask

`ifdef HC_PATTERN_PAUSE_EN
    task automatic test_pause;
        load_seed(16'h0001);
        out_ready = 1'b1;
        start_burst(8'd4);
        @(negedge clk);
        pause = 1'b1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0002) begin
            bad++;
            $display("FAIL pause_w1 got=%b/%h want=1/0002", out_valid, out_data);
        end
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({out_valid, busy} !== 2'b01 || word_cnt !== 8'd2 || out_data !== 16'h0004) begin
                bad++;
                $display("FAIL pause_hold got=%b/%0d/%h want=01/2/0004",
                         {out_valid, busy}, word_cnt, out_data);
            end
        end
        pause = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0004) begin
            bad++;
            $display("FAIL pause_resume got=%b/%h want=1/0004", out_valid, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || word_cnt !== 8'd4) begin
            bad++;
            $display("FAIL pause_done got=%b/%0d want=1/4", done, word_cnt);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_default_burst();
        test_seed_burst();
        test_stall();
        test_zero_seed();
        test_len_zero();
        test_ignore_busy();
        test_start_with_cfg();
        test_reset_mid();
`ifdef HC_PATTERN_PAUSE_EN
        test_pause();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
